ps2_mouse_accum: RTL and testbench

//  Packet assembler and position accumulator feeding the Kempston mouse port decoder.
//  - Consumes the byte stream from the PS/2 receiver: standard 3-byte packets.
//  - Accumulates X/Y movement into wrapping 8-bit absolute positions.
//  - Drives the 17-bit {button, X, Y} bus that the decoder reads directly.

---
 rtl/ps2_mouse_accum.sv | 141 ++++++++++++++
 tb/tb_ps2_mouse_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_accum.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_accum
//  Description : Assembles standard 3-byte PS/2 mouse packets and accumulates
//                the movement into wrapping 8-bit absolute X/Y positions that
//                the Kempston mouse port decoder reads as a 17-bit bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_accum #(
    parameter int         SENS_SHIFT = 2,
    parameter int         TIMEOUT    = 50000,
    parameter logic [7:0] X_INIT     = 8'h80,
    parameter logic [7:0] Y_INIT     = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [7:0]  ps2_byte,
    input  logic        ps2_byte_valid,
    output logic [16:0] ps2_mouse,
    output logic        mouse_new,
    output logic        sync_err
);

    localparam int ACC_W = 8 + SENS_SHIFT;
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    // Positions carry SENS_SHIFT fraction bits below the visible 8 bits.
    localparam logic [ACC_W-1:0] ACC_X_INIT = ACC_W'(X_INIT) << SENS_SHIFT;
    localparam logic [ACC_W-1:0] ACC_Y_INIT = ACC_W'(Y_INIT) << SENS_SHIFT;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_DX  = 2'd1,
        ST_DY  = 2'd2
    } state_t;

    state_t             state, state_nxt, cur;
    // Only the header bits that matter are kept:
    // [5]=Y overflow, [4]=X overflow, [3]=Y sign, [2]=X sign, [1:0]=right/left
    logic [5:0]         hdr, hdr_nxt;
    logic [7:0]         dx, dx_nxt;
    logic [GAP_W-1:0]   gap, gap_nxt;
    logic [ACC_W-1:0]   acc_x, acc_x_nxt, acc_y, acc_y_nxt;
    logic [ACC_W-1:0]   dx_add, dy_add;
    logic               button, button_nxt;
    logic               mouse_new_nxt, sync_err_nxt;
    logic               timeout;

    // Packet FSM, gap timer and accumulator next-state logic.
    always_comb begin
        state_nxt     = state;
        hdr_nxt       = hdr;
        dx_nxt        = dx;
        gap_nxt       = gap;
        acc_x_nxt     = acc_x;
        acc_y_nxt     = acc_y;
        button_nxt    = button;
        mouse_new_nxt = 1'b0;
        sync_err_nxt  = 1'b0;
        cur           = state;
        timeout       = (state != ST_HDR) && (gap == GAP_W'(TIMEOUT));
        // 9-bit two's complement deltas, sign-extended (or truncated) to the accumulator width
        dx_add        = ACC_W'($signed({hdr[2], dx}));
        dy_add        = ACC_W'($signed({hdr[3], ps2_byte}));

        if (clear) begin
            // Clear beats everything, including a same-cycle commit or strobe.
            state_nxt  = ST_HDR;
            gap_nxt    = '0;
            acc_x_nxt  = ACC_X_INIT;
            acc_y_nxt  = ACC_Y_INIT;
            button_nxt = 1'b0;
        end else begin
            if (timeout) begin
                // Abandon the partial packet; a coinciding byte is judged as a header.
                cur          = ST_HDR;
                state_nxt    = ST_HDR;
                gap_nxt      = '0;
                sync_err_nxt = 1'b1;
            end else if (state != ST_HDR) begin
                gap_nxt = gap + 1'b1;
            end

            if (ps2_byte_valid) begin
                gap_nxt = '0;
                case (cur)
                    ST_HDR: begin
                        if (ps2_byte[3]) begin
                            hdr_nxt   = {ps2_byte[7:4], ps2_byte[1:0]};
                            state_nxt = ST_DX;
                        end else begin
                            sync_err_nxt = 1'b1;
                        end
                    end
                    ST_DX: begin
                        dx_nxt    = ps2_byte;
                        state_nxt = ST_DY;
                    end
                    ST_DY: begin
                        state_nxt = ST_HDR;
                        if (!hdr[4]) acc_x_nxt = acc_x + dx_add;
                        if (!hdr[5]) acc_y_nxt = acc_y + dy_add;
                        button_nxt    = hdr[0] | hdr[1];
                        mouse_new_nxt = 1'b1;
                    end
                    default: state_nxt = ST_HDR;
                endcase
            end
        end
    end

    // State, packet latches, accumulators and output pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_HDR;
            hdr       <= '0;
            dx        <= '0;
            gap       <= '0;
            acc_x     <= ACC_X_INIT;
            acc_y     <= ACC_Y_INIT;
            button    <= 1'b0;
            mouse_new <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hdr       <= hdr_nxt;
            dx        <= dx_nxt;
            gap       <= gap_nxt;
            acc_x     <= acc_x_nxt;
            acc_y     <= acc_y_nxt;
            button    <= button_nxt;
            mouse_new <= mouse_new_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

    assign ps2_mouse = {button, acc_x[ACC_W-1 -: 8], acc_y[ACC_W-1 -: 8]};

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_mouse_accum
//  Description : Self-checking bench for ps2_mouse_accum. Two instances
//                (SENS_SHIFT 0 and 2) share one stimulus stream and are
//                compared every cycle against a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_accum;

    localparam int TMO = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  ps2_byte = 8'h00;
    logic        ps2_byte_valid = 1'b0;
    logic [16:0] mouse0, mouse2;
    logic        new0, new2, err0, err2;

    int total = 0;
    int bad   = 0;

    // Reference model state: positions kept as plain integers with fraction bits
    int shift_m [2] = '{0, 2};
    int acc_x_m [2];
    int acc_y_m [2];
    int btn_m;
    int pkt [$];
    int idle_m;
    bit exp_new, exp_err;

    ps2_mouse_accum #(.SENS_SHIFT(0), .TIMEOUT(TMO), .X_INIT(8'h80), .Y_INIT(8'h00)) dut0 (
        .clk_sys(clk), .reset_n(reset_n), .clear(clear), .ps2_byte(ps2_byte),
        .ps2_byte_valid(ps2_byte_valid), .ps2_mouse(mouse0), .mouse_new(new0), .sync_err(err0));

    ps2_mouse_accum #(.SENS_SHIFT(2), .TIMEOUT(TMO), .X_INIT(8'h80), .Y_INIT(8'h00)) dut2 (
        .clk_sys(clk), .reset_n(reset_n), .clear(clear), .ps2_byte(ps2_byte),
        .ps2_byte_valid(ps2_byte_valid), .ps2_mouse(mouse2), .mouse_new(new2), .sync_err(err2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_positions_init();
        for (int i = 0; i < 2; i++) begin
            acc_x_m[i] = 'h80 << shift_m[i];
            acc_y_m[i] = 0;
        end
        btn_m  = 0;
        idle_m = 0;
        pkt.delete();
    endtask

    task automatic model_reset();
        model_positions_init();
        exp_new = 0;
        exp_err = 0;
    endtask

    function automatic logic [16:0] exp_mouse(input int i);
        int x, y;
        x = (acc_x_m[i] >> shift_m[i]) & 255;
        y = (acc_y_m[i] >> shift_m[i]) & 255;
        return 17'((btn_m << 16) | (x << 8) | y);
    endfunction

    task automatic model_commit();
        int h, dxv, dyv, m;
        h   = pkt[0];
        dxv = pkt[1] - (((h >> 4) & 1) * 256);
        dyv = pkt[2] - (((h >> 5) & 1) * 256);
        for (int i = 0; i < 2; i++) begin
            m = 1 << (8 + shift_m[i]);
            if ((h & 'h40) == 0) acc_x_m[i] = (((acc_x_m[i] + dxv) % m) + m) % m;
            if ((h & 'h80) == 0) acc_y_m[i] = (((acc_y_m[i] + dyv) % m) + m) % m;
        end
        btn_m   = ((h & 3) != 0) ? 1 : 0;
        exp_new = 1;
    endtask

    // One clock of the model: what the outputs must show after this cycle's edge.
    task automatic model_step(input bit clr, input bit v, input int b);
        exp_new = 0;
        exp_err = 0;
        if (clr) begin
            model_positions_init();
            return;
        end
        if (pkt.size() > 0 && idle_m == TMO) begin
            pkt.delete();
            exp_err = 1;
            idle_m  = 0;
        end
        if (v) begin
            idle_m = 0;
            if (pkt.size() == 0) begin
                if ((b & 8) != 0) pkt.push_back(b);
                else exp_err = 1;
            end else begin
                pkt.push_back(b);
                if (pkt.size() == 3) begin
                    model_commit();
                    pkt.delete();
                end
            end
        end else if (pkt.size() > 0) begin
            idle_m++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_mouse0"}, mouse0, exp_mouse(0));
        chk({tag, "_mouse2"}, mouse2, exp_mouse(1));
        chk({tag, "_new0"},   17'(new0), 17'(exp_new));
        chk({tag, "_new2"},   17'(new2), 17'(exp_new));
        chk({tag, "_err0"},   17'(err0), 17'(exp_err));
        chk({tag, "_err2"},   17'(err2), 17'(exp_err));
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic tick(input bit clr, input bit v, input logic [7:0] b);
        clear          = clr;
        ps2_byte_valid = v;
        ps2_byte       = b;
        model_step(clr, v, int'(b));
        @(posedge clk);
        #1;
        check_outputs("cyc");
        clear          = 1'b0;
        ps2_byte_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y);
        tick(1'b0, 1'b1, h);
        tick(1'b0, 1'b1, x);
        tick(1'b0, 1'b1, y);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        clear          = 1'b0;
        ps2_byte_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int r;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        chk("por_const", mouse0, 17'h08000);
        reset_n = 1'b1;

        // 1: basic packet, latency one clock after the third byte
        send_pkt(8'h08, 8'h05, 8'h03);
        chk("t1_pos", mouse0, 17'h08503);
        chk("t1_new", 17'(new0), 17'h1);
        tick(1'b0, 1'b0, 8'h00);
        chk("t1_new_gone", 17'(new0), 17'h0);

        // 2: negative deltas, Y wraps below zero
        tick(1'b1, 1'b0, 8'h00);
        send_pkt(8'h38, 8'hFF, 8'hFE);
        chk("t2_pos", mouse0, 17'h07FFE);

        // 3: X overflow leaves X alone; button bit follows header
        tick(1'b1, 1'b0, 8'h00);
        send_pkt(8'h48, 8'h10, 8'h10);
        chk("t3_ovf", mouse0, 17'h08010);
        send_pkt(8'h09, 8'h00, 8'h00);
        chk("t3_btn", mouse0, 17'h18010);

        // 4: rejected header then a normal packet
        tick(1'b0, 1'b1, 8'h00);
        chk("t4_err", 17'(err0), 17'h1);
        send_pkt(8'h08, 8'h01, 8'h01);

        // 5: timeout with the next header arriving on the timeout cycle
        tick(1'b0, 1'b1, 8'h08);
        tick(1'b0, 1'b1, 8'h05);
        repeat (TMO) tick(1'b0, 1'b0, 8'h00);
        send_pkt(8'h08, 8'h02, 8'h00);
        // gap one short of the limit: the packet survives
        tick(1'b0, 1'b1, 8'h08);
        repeat (TMO - 1) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h03);
        tick(1'b0, 1'b1, 8'h00);
        // idle long enough for a standalone timeout pulse
        tick(1'b0, 1'b1, 8'h08);
        repeat (TMO + 3) tick(1'b0, 1'b0, 8'h00);

        // 6: fractional accumulation and clear coinciding with commit
        tick(1'b1, 1'b0, 8'h00);
        repeat (3) send_pkt(8'h08, 8'h01, 8'h00);
        chk("t6_frac3", mouse2, 17'h08000);
        send_pkt(8'h08, 8'h01, 8'h00);
        chk("t6_frac4", mouse2, 17'h08100);
        tick(1'b0, 1'b1, 8'h08);
        tick(1'b0, 1'b1, 8'h20);
        tick(1'b1, 1'b1, 8'h20);
        chk("t6_clr_pos", mouse2, 17'h08000);
        chk("t6_clr_new", 17'(new2), 17'h0);

        // Reset in the middle of a packet
        send_pkt(8'h08, 8'h11, 8'h22);
        tick(1'b0, 1'b1, 8'h18);
        tick(1'b0, 1'b1, 8'h40);
        async_reset();
        send_pkt(8'h08, 8'h04, 8'h04);

        // Randomized traffic, including back-to-back strobes, clears and gaps
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                repeat (TMO - 1 + int'($urandom_range(0, 2))) tick(1'b0, 1'b0, 8'h00);
            end else if (r == 1) begin
                async_reset();
            end else begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 9) < 8) b[3] = 1'b1;
                tick(r < 5, r < 120, b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
